// File: rtl/rf_dump.sv
// RISC-V integer register file (x0 reads as zero) with a valid/ready dump sequencer that streams every register.
// Define RF_DUMP_SKIP_ZERO_EN to start the dump at x1 and never emit x0.
module rf_dump #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             dump_start,
    output logic             dump_busy,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [AW-1:0]    dump_addr,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_last
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
`ifdef RF_DUMP_SKIP_ZERO_EN
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
`else
    localparam logic [AW-1:0] FIRST_IDX = '0;
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    idx_p0, idx_d;
    logic [WIDTH-1:0] data_p0;
    logic             last_p0;
    logic             load;
    logic             we;
    logic [WIDTH-1:0] snap;

    assign we  = wen && (waddr != '0);
    assign rd1 = (raddr1 == '0) ? '0 : mem[raddr1];
    assign rd2 = (raddr2 == '0) ? '0 : mem[raddr2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wd;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_p0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = SEND;
                    idx_d   = FIRST_IDX;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (idx_p0 == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_p0 + AW'(1);
                        load  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A write landing on the same edge as the beat load is forwarded into the snapshot.
    always_comb begin
        snap = mem[idx_d];
        if (we && (waddr == idx_d)) snap = wd;
    end

    // Beat stage: fields change only on a load, so a stalled beat stays frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_p0  <= '0;
            data_p0 <= '0;
            last_p0 <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                idx_p0  <= idx_d;
                data_p0 <= snap;
                last_p0 <= (idx_d == LAST_IDX);
            end else if (state_d == IDLE) begin
                last_p0 <= 1'b0;
            end
        end
    end

    assign dump_busy  = (state_q == SEND);
    assign dump_valid = (state_q == SEND);
    assign dump_addr  = idx_p0;
    assign dump_data  = data_p0;
    assign dump_last  = last_p0;

endmodule

// File: tb/tb_rf_dump.sv
// Self-checking bench for rf_dump: array reference model for the register file and a beat scoreboard for the dump.
module tb_rf_dump;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;
`ifdef RF_DUMP_SKIP_ZERO_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wen = 1'b0;
    logic [AW-1:0]    waddr = '0;
    logic [WIDTH-1:0] wd = '0;
    logic [AW-1:0]    raddr1 = '0;
    logic [AW-1:0]    raddr2 = '0;
    logic [WIDTH-1:0] rd1, rd2;
    logic             dump_start = 1'b0;
    logic             dump_busy, dump_valid;
    logic             dump_ready = 1'b0;
    logic [AW-1:0]    dump_addr;
    logic [WIDTH-1:0] dump_data;
    logic             dump_last;

    logic [WIDTH-1:0] model [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    rf_dump #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wd(wd),
        .raddr1(raddr1), .raddr2(raddr2), .rd1(rd1), .rd2(rd2),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_last(dump_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        wen = 1'b1; waddr = a; wd = d;
        @(posedge clk);
        if (a != 0) model[a] = d;
        #1 wen = 1'b0;
    endtask

    task automatic load_pattern();
        for (int k = 1; k < DEPTH; k++) do_write(AW'(k), WIDTH'(k * 32'h11));
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            raddr2 = AW'(i);
            #1;
            n_checks++;
            if (rd2 !== model[i]) begin
                n_fail++;
                $display("FAIL %s x%0d: rd2=%h expected %h", tag, i, rd2, model[i]);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if ({dump_valid, dump_busy, dump_last} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s: valid/busy/last=%b expected 000", tag, {dump_valid, dump_busy, dump_last});
        end
    endtask

    // mode 0: ready high; 1: stall at x7 with write; 2: random ready/writes;
    // 3: extra start pulses; 4: reset at beat x10
    task automatic run_dump(input int mode, output int beats, output int cycles, output bit aborted);
        int exp_addr;
        logic [WIDTH-1:0] exp_data;
        bit acc, done;
        int hold;
        beats = 0; cycles = 0; aborted = 0; done = 0; hold = 0;
        @(negedge clk);
        dump_start = 1'b1;
        dump_ready = 1'b0;
        @(posedge clk);
        exp_addr = FIRST;
        exp_data = model[FIRST];
        #1 dump_start = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            n_checks++;
            if ({dump_valid, dump_busy} !== 2'b11 || dump_addr !== AW'(exp_addr) ||
                dump_data !== exp_data || dump_last !== (exp_addr == DEPTH - 1)) begin
                n_fail++;
                $display("FAIL beat mode%0d: v=%b b=%b addr=%0d data=%h last=%b expected v=1 b=1 addr=%0d data=%h last=%b",
                         mode, dump_valid, dump_busy, dump_addr, dump_data, dump_last,
                         exp_addr, exp_data, exp_addr == DEPTH - 1);
            end
            if (mode == 4 && exp_addr == 10) begin
                rst_n = 1'b0;
                dump_ready = 1'b1;
                @(posedge clk);
                #1;
                clear_model();
                n_checks++;
                if ({dump_valid, dump_busy, dump_last} !== 3'b000 || dump_addr !== '0 || dump_data !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid_dump: v=%b b=%b l=%b addr=%0d data=%h expected all 0",
                             dump_valid, dump_busy, dump_last, dump_addr, dump_data);
                end
                check_all_regs("reset_mid_dump_regs");
                rst_n = 1'b1;
                aborted = 1;
                return;
            end
            wen = 1'b0;
            case (mode)
                1: begin
                    if (exp_addr == 7 && hold < 3) begin
                        dump_ready = 1'b0;
                        wen = 1'b1; waddr = AW'(7); wd = 32'hAAAA;
                        hold++;
                    end else begin
                        dump_ready = 1'b1;
                    end
                end
                2: begin
                    dump_ready = 1'($urandom_range(0, 1));
                    wen = 1'($urandom_range(0, 1));
                    waddr = AW'($urandom);
                    wd = $urandom;
                end
                3: begin
                    dump_ready = 1'b1;
                    dump_start = (exp_addr % 4 == 0) || (exp_addr == DEPTH - 1);
                end
                default: dump_ready = 1'b1;
            endcase
            cycles++;
            @(posedge clk);
            if (wen && waddr != 0) model[waddr] = wd;
            acc = dump_ready;
            #1;
            wen = 1'b0;
            dump_start = 1'b0;
            if (acc) begin
                beats++;
                if (exp_addr == DEPTH - 1) done = 1;
                else begin
                    exp_addr++;
                    exp_data = model[exp_addr];
                end
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL dump_timeout mode%0d: beats=%0d expected %0d", mode, beats, DEPTH - FIRST);
        end
        dump_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle_outputs("post_dump_idle");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        check_idle_outputs("reset_ctrl");
        n_checks++;
        if (dump_addr !== '0 || dump_data !== '0) begin
            n_fail++;
            $display("FAIL reset_beat: addr=%0d data=%h expected 0 0", dump_addr, dump_data);
        end
        check_all_regs("reset_regs");
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        do_write(AW'(5), 32'hDEADBEEF);
        raddr1 = AW'(5); raddr2 = '0;
        #1;
        n_checks++;
        if (rd1 !== 32'hDEADBEEF || rd2 !== '0) begin
            n_fail++;
            $display("FAIL write_read: rd1=%h rd2=%h expected deadbeef 00000000", rd1, rd2);
        end
        @(negedge clk);
        wen = 1'b1; waddr = AW'(5); wd = 32'hCAFEF00D;
        #1;
        n_checks++;
        if (rd1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL no_bypass: rd1=%h expected deadbeef", rd1);
        end
        @(posedge clk);
        model[5] = 32'hCAFEF00D;
        #1 wen = 1'b0;
        n_checks++;
        if (rd1 !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL write_after_edge: rd1=%h expected cafef00d", rd1);
        end
    endtask

    task automatic test_x0_write();
        do_write('0, 32'h12345678);
        raddr1 = '0;
        #1;
        n_checks++;
        if (rd1 !== '0) begin
            n_fail++;
            $display("FAIL x0_write: rd1=%h expected 00000000", rd1);
        end
        check_all_regs("x0_write_regs");
    endtask

    task automatic test_random_rw();
        for (int i = 0; i < 40; i++) begin
            do_write(AW'($urandom), $urandom);
            raddr1 = AW'($urandom);
            raddr2 = AW'($urandom);
            #1;
            n_checks++;
            if (rd1 !== model[raddr1] || rd2 !== model[raddr2]) begin
                n_fail++;
                $display("FAIL random_rw: rd1[%0d]=%h rd2[%0d]=%h expected %h %h",
                         raddr1, rd1, raddr2, rd2, model[raddr1], model[raddr2]);
            end
        end
    endtask

    task automatic test_dump_full();
        int beats, cycles;
        bit ab;
        load_pattern();
        run_dump(0, beats, cycles, ab);
        n_checks++;
        if (beats != DEPTH - FIRST || cycles != beats) begin
            n_fail++;
            $display("FAIL dump_full: beats=%0d cycles=%0d expected %0d %0d", beats, cycles, DEPTH - FIRST, DEPTH - FIRST);
        end
    endtask

    task automatic test_backpressure();
        int beats, cycles;
        bit ab;
        load_pattern();
        run_dump(1, beats, cycles, ab);
        n_checks++;
        if (beats != DEPTH - FIRST || cycles != beats + 3) begin
            n_fail++;
            $display("FAIL backpressure: beats=%0d cycles=%0d expected %0d %0d", beats, cycles, DEPTH - FIRST, DEPTH - FIRST + 3);
        end
        raddr1 = AW'(7);
        #1;
        n_checks++;
        if (rd1 !== 32'hAAAA) begin
            n_fail++;
            $display("FAIL backpressure_write: rd1=%h expected 0000aaaa", rd1);
        end
    endtask

    task automatic test_back_to_back();
        int beats, cycles;
        bit ab;
        run_dump(3, beats, cycles, ab);
        n_checks++;
        if (beats != DEPTH - FIRST) begin
            n_fail++;
            $display("FAIL back_to_back: beats=%0d expected %0d", beats, DEPTH - FIRST);
        end
    endtask

    task automatic test_random_dump();
        int beats, cycles;
        bit ab;
        for (int r = 0; r < 3; r++) begin
            run_dump(2, beats, cycles, ab);
            n_checks++;
            if (beats != DEPTH - FIRST) begin
                n_fail++;
                $display("FAIL random_dump: beats=%0d expected %0d", beats, DEPTH - FIRST);
            end
            check_all_regs("random_dump_regs");
        end
    endtask

    task automatic test_reset_mid_dump();
        int beats, cycles;
        bit ab;
        load_pattern();
        run_dump(4, beats, cycles, ab);
        n_checks++;
        if (!ab || beats != 10 - FIRST) begin
            n_fail++;
            $display("FAIL reset_abort: aborted=%0d beats=%0d expected 1 %0d", ab, beats, 10 - FIRST);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle_outputs("after_reset_idle");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0_write();
        test_random_rw();
        test_dump_full();
        test_backpressure();
        test_back_to_back();
        test_random_dump();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
